// File: rtl/mux_nxw_rr_reg_pkg.sv
// Shared constants and helpers for the N-input channel selector and its round-robin arbiter.
package mux_nxw_rr_reg_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of a channel index: ceil(log2(n)), never below one bit.
    function automatic int sel_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_nxw_rr_reg_rr_arb_n.sv
// Round-robin pick: rotate the valids so rr_ptr sits at bit 0, take the lowest set bit,
// then rotate the winner back to its real channel index.
module rr_arb_n
    import mux_nxw_rr_reg_pkg::*;
#(
    parameter int N = 4,
    localparam int SELW = sel_w(N)
) (
    input  logic [N-1:0]    in_valid,
    input  logic [SELW-1:0] rr_ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    logic [N-1:0]    w_rot;
    logic [SELW-1:0] w_pick;
    logic            w_found;

    always_comb begin
        w_rot = '0;
        for (int k = 0; k < N; k++) begin
            w_rot[k] = in_valid[SELW'((k + int'(rr_ptr)) % N)];
        end
    end

    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_pick  = SELW'(k);
            end
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = SELW'((int'(w_pick) + int'(rr_ptr)) % N);
        if (w_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_nxw_rr_reg.sv
// N-channel, WIDTH-bit selector with fixed or round-robin grant and a one-entry
// valid/ready output register that sustains one beat per cycle.
module mux_nxw_rr_reg
    import mux_nxw_rr_reg_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SELW = sel_w(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    dbg_rr_ptr
);

    // Handshake: a beat moves on channel i when in_valid[i] & in_ready[i] at a rising
    // edge; the output beat is consumed when out_valid & out_ready. Neither side may make
    // valid depend on ready; in_ready[i] is high only for the granted channel.

    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_chan;
    logic             r_valid;
    logic [SELW-1:0]  r_rr_ptr;

    logic [N-1:0]     w_rr_grant;
    logic [SELW-1:0]  w_rr_idx;
    logic [N-1:0]     w_fix_grant;
    logic [N-1:0]     w_grant;
    logic             w_load_ok;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;
    logic [SELW-1:0]  w_chan;

    rr_arb_n #(.N(N)) u_arb (
        .in_valid  (in_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_rr_grant),
        .grant_idx (w_rr_idx)
    );

    // A sel outside 0..N-1 matches no channel, so it grants nothing.
    always_comb begin
        w_fix_grant = '0;
        for (int i = 0; i < N; i++) begin
            w_fix_grant[i] = (sel == SELW'(i)) && in_valid[i];
        end
    end

    assign w_grant   = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;
    assign w_load_ok = !r_valid || out_ready;
    assign in_ready  = {N{rst_n && w_load_ok}} & w_grant;
    assign w_xfer    = |(in_ready & in_valid);

    always_comb begin
        w_data = '0;
        w_chan = '0;
        for (int i = 0; i < N; i++) begin
            w_data = w_data | ({WIDTH{w_grant[i]}} & in_data[i*WIDTH +: WIDTH]);
            if (w_grant[i]) begin
                w_chan = w_chan | SELW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_chan  <= w_chan;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Pointer moves past the winner only on round-robin transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_xfer && (mode == MODE_RR)) begin
            r_rr_ptr <= (w_rr_idx == SELW'(N - 1)) ? '0 : w_rr_idx + SELW'(1);
        end
    end

    assign out_data   = r_data;
    assign out_chan   = r_chan;
    assign out_valid  = r_valid;
    assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_mux_nxw_rr_reg.sv
// Directed bench for mux_nxw_rr_reg: reset, fixed select, round-robin order, skip/wrap,
// back-pressure, mid-stream reset and mode switch, plus an N=5 build for out-of-range sel.
module tb_mux_nxw_rr_reg;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SELW  = 2;

    // clock / reset / stimulus signals
    logic               clk;
    logic               rst_n;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    dbg_rr_ptr;

    logic [2:0]         sel5;
    logic [5*8-1:0]     in_data5;
    logic [4:0]         in_valid5;
    logic [4:0]         in_ready5;
    logic [7:0]         out_data5;
    logic [2:0]         out_chan5;
    logic               out_valid5;
    logic [2:0]         dbg_rr_ptr5;

    int n_checks;
    int n_pass;
    logic [SELW-1:0] exp_q[$];
    logic [WIDTH-1:0] ch_data [N];

    mux_nxw_rr_reg #(.N(N), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .sel        (sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    mux_nxw_rr_reg #(.N(5), .WIDTH(8)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (1'b0),
        .sel        (sel5),
        .in_data    (in_data5),
        .in_valid   (in_valid5),
        .in_ready   (in_ready5),
        .out_data   (out_data5),
        .out_chan   (out_chan5),
        .out_valid  (out_valid5),
        .out_ready  (1'b1),
        .dbg_rr_ptr (dbg_rr_ptr5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ch_data[0] = 8'h11;
        ch_data[1] = 8'h22;
        ch_data[2] = 8'hA5;
        ch_data[3] = 8'h44;
        in_data   = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
        in_valid  = 4'b1111;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        sel5      = 3'd7;
        in_data5  = 40'h55_44_33_22_11;
        in_valid5 = 5'b11111;

        // Reset held two cycles with every channel valid.
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);

        // Fixed select on channel 2.
        rst_n = 1'b1;
        sel   = 2'd2;
        #1;
        check("fix_in_ready", 32'(in_ready), 32'b0100);
        step();
        check("fix_out_valid", 32'(out_valid), 32'd1);
        check("fix_out_data", 32'(out_data), 32'hA5);
        check("fix_out_chan", 32'(out_chan), 32'd2);
        check("fix_rr_ptr_hold", 32'(dbg_rr_ptr), 32'd0);
        check("n5_sel7_no_grant", 32'(in_ready5), 32'd0);
        sel5 = 3'd4;
        #1;
        check("n5_sel4_grant", 32'(in_ready5), 32'b10000);

        // Round-robin, all channels valid, consumer always ready.
        mode = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        for (int k = 0; k < 6; k++) begin
            logic [SELW-1:0] e;
            step();
            e = exp_q.pop_front();
            check($sformatf("rr_chan_%0d", k), 32'(out_chan), 32'(e));
            check($sformatf("rr_data_%0d", k), 32'(out_data), 32'(ch_data[e]));
            check($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'd1);
        end
        check("rr_ptr_after6", 32'(dbg_rr_ptr), 32'd2);

        // Steer the pointer to 1, then skip over idle channels and wrap.
        in_valid = 4'b0001;
        step();
        check("skip_prep_chan", 32'(out_chan), 32'd0);
        check("skip_prep_ptr", 32'(dbg_rr_ptr), 32'd1);
        in_valid = 4'b1001;
        step();
        check("skip_chan_a", 32'(out_chan), 32'd3);
        step();
        check("skip_chan_b", 32'(out_chan), 32'd0);
        step();
        check("skip_chan_c", 32'(out_chan), 32'd3);
        check("wrap_ptr", 32'(dbg_rr_ptr), 32'd0);

        // Back-pressure for three cycles.
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        check("bp_in_ready_now", 32'(in_ready), 32'd0);
        step();
        step();
        step();
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_chan", 32'(out_chan), 32'd3);
        check("bp_out_data", 32'(out_data), 32'h44);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b0001);
        step();
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_chan", 32'(out_chan), 32'd0);
        check("bp_next_data", 32'(out_data), 32'h11);
        check("bp_next_ptr", 32'(dbg_rr_ptr), 32'd1);

        // Reset during round-robin traffic.
        rst_n = 1'b0;
        step();
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        check("mrst_resume_chan", 32'(out_chan), 32'd0);
        check("mrst_resume_ptr", 32'(dbg_rr_ptr), 32'd1);

        // Mode switch while stalled leaves the held beat alone.
        out_ready = 1'b0;
        step();
        mode = 1'b0;
        sel  = 2'd3;
        #1;
        check("msw_in_ready", 32'(in_ready), 32'd0);
        step();
        check("msw_held_chan", 32'(out_chan), 32'd0);
        check("msw_held_data", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        #1;
        check("msw_fix_ready", 32'(in_ready), 32'b1000);
        step();
        check("msw_fix_chan", 32'(out_chan), 32'd3);
        check("msw_ptr_hold", 32'(dbg_rr_ptr), 32'd1);

        // Pop with nothing to load: valid drops, data and channel hold.
        in_valid = 4'b0000;
        step();
        check("pop_out_valid", 32'(out_valid), 32'd0);
        check("pop_out_chan", 32'(out_chan), 32'd3);
        check("pop_out_data", 32'(out_data), 32'h44);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
